// File: rtl/imm_extender_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_extender_pipe_if
// Handshake bundle between an immediate producer, the extender pipe and the
// downstream consumer.
//
// Signals
//   inValid   producer -> pipe   an immediate is on numIn/mode
//   inReady   pipe -> producer   pipe accepts an input this cycle
//   numIn     producer -> pipe   raw immediate field, IN_W bits
//   mode      producer -> pipe   extension mode for numIn
//   outValid  pipe -> consumer   numOut/modeOut hold a valid result
//   outReady  consumer -> pipe   consumer takes the result this cycle
//   numOut    pipe -> consumer   extended immediate, OUT_W bits
//   modeOut   pipe -> consumer   mode that produced numOut
//   level     pipe -> observer   current occupancy, 0..2
//
// Modports
//   slave   the extender pipe itself
//   master  whoever drives the pipe (producer + consumer side)
// ---------------------------------------------------------------------------
interface imm_extender_pipe_if #(
    parameter int IN_W  = 13,
    parameter int OUT_W = 32
);
    logic             inValid;
    logic             inReady;
    logic [IN_W-1:0]  numIn;
    logic [1:0]       mode;
    logic             outValid;
    logic             outReady;
    logic [OUT_W-1:0] numOut;
    logic [1:0]       modeOut;
    logic [1:0]       level;

    modport slave (
        input  inValid,
        input  numIn,
        input  mode,
        input  outReady,
        output inReady,
        output outValid,
        output numOut,
        output modeOut,
        output level
    );

    modport master (
        output inValid,
        output numIn,
        output mode,
        output outReady,
        input  inReady,
        input  outValid,
        input  numOut,
        input  modeOut,
        input  level
    );
endinterface

// File: rtl/imm_extender_pipe.sv
// ---------------------------------------------------------------------------
// imm_extender_pipe
// Extends an IN_W-bit immediate field to OUT_W bits in one of four modes
// (sign, zero, sign then shift-left by SHIFT, upper placement) and buffers
// the results in a two-entry FIFO (head register + skid register) so the
// producer never has to look at the consumer's ready in the same cycle.
//
// Ports
//   clk    single clock, all state changes on the rising edge
//   nRst   synchronous active-low reset
//   bus    imm_extender_pipe_if.slave handshake bundle:
//            inValid/inReady/numIn/mode        input side
//            outValid/outReady/numOut/modeOut  output side
//            level                             occupancy 0..2
//
// Extension modes
//   00 SIGN      numIn sign-extended
//   01 ZERO      numIn zero-extended
//   10 SIGN_SHL  SIGN result shifted left by SHIFT, truncated to OUT_W
//   11 UPPER     numIn in the top IN_W bits, zeros below
// ---------------------------------------------------------------------------
module imm_extender_pipe #(
    parameter int IN_W  = 13,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic                clk,
    input  logic                nRst,
    imm_extender_pipe_if.slave  bus
);

    // Parameter combinations that would make the extension ill-formed are
    // refused at elaboration instead of silently truncating.
    generate
        if ((IN_W < 1) || (SHIFT < 0) || (IN_W >= OUT_W) || (IN_W + SHIFT > OUT_W)) begin : g_bad_params
            $error("imm_extender_pipe: requires IN_W < OUT_W and IN_W+SHIFT <= OUT_W");
        end
    endgenerate

    localparam int PAD_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    typedef enum logic [1:0] {
        MODE_SIGN     = 2'b00,
        MODE_ZERO     = 2'b01,
        MODE_SIGN_SHL = 2'b10,
        MODE_UPPER    = 2'b11
    } ext_mode_t;

    occ_state_t       state;
    occ_state_t       state_next;

    logic             in_ready;
    logic             out_valid;
    logic [1:0]       occupancy;
    logic             push;
    logic             pop;

    logic             load_head_new;
    logic             load_head_skid;
    logic             load_skid;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] shl_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] ext_value;

    logic [OUT_W-1:0] head_num;
    logic [1:0]       head_mode;
    logic [OUT_W-1:0] skid_num;
    logic [1:0]       skid_mode;

    // Extension is purely combinational on the input side; only the
    // finished value is stored, so the output side is a plain register.
    always_comb begin
        sign_ext  = {{PAD_W{bus.numIn[IN_W-1]}}, bus.numIn};
        zero_ext  = {{PAD_W{1'b0}}, bus.numIn};
        shl_ext   = sign_ext << SHIFT;
        upper_ext = {bus.numIn, {PAD_W{1'b0}}};
        ext_value = sign_ext;
        case (ext_mode_t'(bus.mode))
            MODE_SIGN:     ext_value = sign_ext;
            MODE_ZERO:     ext_value = zero_ext;
            MODE_SIGN_SHL: ext_value = shl_ext;
            MODE_UPPER:    ext_value = upper_ext;
            default:       ext_value = sign_ext;
        endcase
    end

    // Handshake qualifiers; inReady is derived from occupancy only, never
    // from outReady, which keeps the two sides free of a combinational path.
    assign push = bus.inValid && in_ready;
    assign pop  = out_valid && bus.outReady;

    // Occupancy state register; reset wins over any push or pop.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy next-state. FULL cannot push because inReady is low there.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_next = FULL;
                end else if (pop && !push) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs and datapath load enables. A push into an empty
    // head (EMPTY, or ONE with a simultaneous pop) goes straight to the head;
    // a push behind a held head lands in the skid; a pop from FULL promotes
    // the skid entry to the head.
    always_comb begin
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        occupancy      = 2'd0;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                in_ready      = nRst;
                occupancy     = 2'd0;
                load_head_new = push;
            end
            ONE: begin
                in_ready      = nRst;
                out_valid     = 1'b1;
                occupancy     = 2'd1;
                load_head_new = push && pop;
                load_skid     = push && !pop;
            end
            FULL: begin
                out_valid      = 1'b1;
                occupancy      = 2'd2;
                load_head_skid = pop;
            end
            default: begin
                occupancy = 2'd0;
            end
        endcase
    end

    // Head and skid storage; both entries are cleared on reset so a fresh
    // start shows an all-zero result with mode 00.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            head_num  <= '0;
            head_mode <= 2'b00;
            skid_num  <= '0;
            skid_mode <= 2'b00;
        end else begin
            if (load_head_new) begin
                head_num  <= ext_value;
                head_mode <= bus.mode;
            end else if (load_head_skid) begin
                head_num  <= skid_num;
                head_mode <= skid_mode;
            end
            if (load_skid) begin
                skid_num  <= ext_value;
                skid_mode <= bus.mode;
            end
        end
    end

    assign bus.inReady  = in_ready;
    assign bus.outValid = out_valid;
    assign bus.numOut   = head_num;
    assign bus.modeOut  = head_mode;
    assign bus.level    = occupancy;

endmodule

// File: tb/tb_imm_extender_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_extender_pipe
// Self-checking bench for imm_extender_pipe (IN_W=13, OUT_W=32, SHIFT=2).
// Inputs change 1 time unit after each rising edge; outputs are sampled on
// the falling edge. A queue holds expected results in acceptance order: an
// entry is pushed when the bench's own occupancy model says the input is
// accepted and popped when the model says the consumer takes the head.
// ---------------------------------------------------------------------------
module tb_imm_extender_pipe;

    localparam int IN_W  = 13;
    localparam int OUT_W = 32;
    localparam int SHIFT = 2;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] num;
    } entry_t;

    logic        clk = 1'b0;
    logic        nRst;
    entry_t      sb[$];
    int          check_count = 0;
    int          pass_count  = 0;
    int          fail_count  = 0;
    int          accepted    = 0;
    logic [31:0] stim_expected;

    imm_extender_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    imm_extender_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Reference extension written arithmetically rather than bit-wise.
    function automatic logic [31:0] model(input logic [12:0] n, input logic [1:0] m);
        logic signed [31:0] s;
        logic [31:0]        u;
        s = $signed({n, 19'b0}) >>> 19;
        u = 32'(n);
        case (m)
            2'b00:   return s;
            2'b01:   return u;
            2'b10:   return s * 32'sd4;
            default: return u * 32'h0008_0000;
        endcase
    endfunction

    // One comparison: counts it, and on mismatch reports tag and both values.
    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Falling-edge sampling: occupancy/handshake against the model, head
    // entry against the queue front, then update the model for the edge.
    task automatic checkOutput();
        int   exp_level;
        logic exp_ready;
        exp_level = sb.size();
        exp_ready = nRst && (exp_level < 2);
        checkEq("level",    32'(bus.level),    32'(exp_level));
        checkEq("outValid", 32'(bus.outValid), 32'(exp_level > 0));
        checkEq("inReady",  32'(bus.inReady),  32'(exp_ready));
        if (!nRst) begin
            sb.delete();
        end else begin
            if (exp_level > 0) begin
                checkEq("numOut",  bus.numOut,        sb[0].num);
                checkEq("modeOut", 32'(bus.modeOut),  32'(sb[0].mode));
                if (bus.outReady) begin
                    void'(sb.pop_front());
                end
            end
            if (bus.inValid && exp_ready) begin
                sb.push_back({bus.mode, stim_expected});
                accepted++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [12:0] n, input logic [1:0] m,
                                 input logic ordy, input logic [31:0] exp);
        bus.inValid   = v;
        bus.numIn     = n;
        bus.mode      = m;
        bus.outReady  = ordy;
        stim_expected = exp;
        cycle();
    endtask

    initial begin
        logic [12:0] rn;
        logic [1:0]  rm;
        int          target;
        int          guard;

        nRst          = 1'b0;
        bus.inValid   = 1'b0;
        bus.numIn     = '0;
        bus.mode      = 2'b00;
        bus.outReady  = 1'b1;
        stim_expected = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst_numOut",  bus.numOut,       32'h0);
        checkEq("rst_modeOut", 32'(bus.modeOut), 32'h0);
        cycle();

        // First edge after release accepts a push; sign mode all-ones
        nRst = 1'b1;
        applyStimulus(1'b1, 13'h1FFF, 2'b00, 1'b1, 32'hFFFF_FFFF);

        // Zero / sign-shift / upper modes back to back
        applyStimulus(1'b1, 13'h1000, 2'b01, 1'b1, 32'h0000_1000);
        applyStimulus(1'b1, 13'h1000, 2'b10, 1'b1, 32'hFFFF_C000);
        applyStimulus(1'b1, 13'h1000, 2'b11, 1'b1, 32'h8000_0000);
        applyStimulus(1'b1, 13'h0001, 2'b11, 1'b1, 32'h0008_0000);
        applyStimulus(1'b0, 13'h0000, 2'b00, 1'b1, 32'h0);
        applyStimulus(1'b0, 13'h0000, 2'b00, 1'b1, 32'h0);

        // Backpressure: fill to two, third push refused, head held stable
        applyStimulus(1'b1, 13'h0005, 2'b00, 1'b0, 32'h0000_0005);
        applyStimulus(1'b1, 13'h1FFE, 2'b00, 1'b0, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 13'h0AAA, 2'b00, 1'b0, 32'h0000_0AAA);
        applyStimulus(1'b0, 13'h0000, 2'b00, 1'b0, 32'h0);
        applyStimulus(1'b0, 13'h0000, 2'b00, 1'b1, 32'h0);
        applyStimulus(1'b0, 13'h0000, 2'b00, 1'b1, 32'h0);
        applyStimulus(1'b0, 13'h0000, 2'b00, 1'b1, 32'h0);

        // Random stream of 100 accepted pushes with random consumer stalls
        target = accepted + 100;
        guard  = 0;
        while ((accepted < target) && (guard < 2000)) begin
            rn = 13'($urandom);
            rm = 2'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, rn, rm,
                          $urandom_range(0, 2) != 0, model(rn, rm));
            guard++;
        end
        checkEq("random_pushes", 32'(accepted), 32'(target));

        guard = 0;
        while ((sb.size() > 0) && (guard < 20)) begin
            applyStimulus(1'b0, 13'h0000, 2'b00, 1'b1, 32'h0);
            guard++;
        end
        checkEq("drain_empty", 32'(sb.size()), 32'h0);

        // Reset while full, with push and pop asserted
        applyStimulus(1'b1, 13'h0123, 2'b01, 1'b0, 32'h0000_0123);
        applyStimulus(1'b1, 13'h0456, 2'b01, 1'b0, 32'h0000_0456);
        nRst = 1'b0;
        applyStimulus(1'b1, 13'h0789, 2'b00, 1'b1, 32'h0000_0789);
        checkEq("rst_full_numOut",  bus.numOut,       32'h0);
        checkEq("rst_full_modeOut", 32'(bus.modeOut), 32'h0);
        nRst = 1'b1;
        applyStimulus(1'b1, 13'h1ABC, 2'b10, 1'b1, model(13'h1ABC, 2'b10));
        applyStimulus(1'b0, 13'h0000, 2'b00, 1'b1, 32'h0);
        applyStimulus(1'b0, 13'h0000, 2'b00, 1'b1, 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/imm_extender_pipe.md
IMM_EXTENDER_PIPE -- requirements
Module: imm_extender_pipe

Interface
REQ-001 SHALL provide parameter IN_W, default 13, immediate field width in bits.
REQ-002 SHALL provide parameter OUT_W, default 32, extended datapath width in bits.
REQ-003 SHALL provide parameter SHIFT, default 2, left-shift amount for branch-offset mode.
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL provide port nRst  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port inValid  input  1  producer has an immediate on numIn/mode.
REQ-007 SHALL provide port inReady  output  1  block accepts an input this cycle.
REQ-008 SHALL provide port numIn  input  IN_W  raw immediate field.
REQ-009 SHALL provide port mode  input  2  extension mode for numIn.
REQ-010 SHALL provide port outValid  output  1  numOut/modeOut hold a valid result.
REQ-011 SHALL provide port outReady  input  1  consumer takes the result this cycle.
REQ-012 SHALL provide port numOut  output  OUT_W  extended immediate.
REQ-013 SHALL provide port modeOut  output  2  mode that produced numOut.
REQ-014 SHALL provide port level  output  2  current occupancy, 0..2.

Function
REQ-015 SHALL support only IN_W < OUT_W and IN_W+SHIFT <= OUT_W; other values SHALL be rejected at elaboration.
REQ-016 Mode 00 SIGN SHALL give numIn[IN_W-1] replicated into bits OUT_W-1..IN_W, followed by numIn.
REQ-017 Mode 01 ZERO SHALL give zeros in bits OUT_W-1..IN_W, followed by numIn.
REQ-018 Mode 10 SIGN_SHL SHALL give the SIGN result shifted left by SHIFT, zero-filled, truncated to OUT_W.
REQ-019 Mode 11 UPPER SHALL place numIn in bits OUT_W-1..OUT_W-IN_W with zeros below.
REQ-020 SHALL compute the extension combinationally at input and store the result in a 2-entry FIFO (head register plus skid register).
REQ-021 SHALL track occupancy states EMPTY (level 0), ONE (1), FULL (2).
REQ-022 Push SHALL be inValid && inReady; pop SHALL be outValid && outReady.
REQ-023 inReady SHALL be 1 iff level < 2 and nRst = 1; it SHALL NOT depend on outReady.
REQ-024 outValid SHALL be 1 iff level > 0; numOut/modeOut SHALL always show the head entry.
REQ-025 Latency SHALL be 1 cycle: an input pushed at edge k SHALL appear on numOut with outValid = 1 after edge k.
REQ-026 Transitions: EMPTY+push -> ONE; ONE+push-pop -> FULL; ONE+pop-push -> EMPTY; ONE+push+pop -> ONE, new entry becomes head; FULL+pop -> ONE, skid moves to head; all other cases hold state.
REQ-027 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-028 While outValid = 1 and outReady = 0, numOut and modeOut SHALL stay stable.
REQ-029 Inputs presented while inReady = 0 SHALL be ignored.

Reset
REQ-030 At a rising edge with nRst = 0: level SHALL become 0, outValid 0, numOut all-zero, modeOut 00, and both FIFO entries cleared.
REQ-031 Reset SHALL take priority over push and pop in the same cycle; in-flight entries SHALL be discarded.
REQ-032 During the first edge after nRst returns to 1, inReady SHALL be 1 and the block SHALL accept a push.

Verification (IN_W=13, OUT_W=32, SHIFT=2, outReady=1 unless stated)
REQ-033 Push numIn=13'h1FFF, mode=00 -> one cycle later numOut=32'hFFFFFFFF, modeOut=00, outValid=1.
REQ-034 Push 13'h1000 with mode 01, then 10, then 11 on consecutive cycles -> numOut 32'h00001000, 32'hFFFFC000, 32'h80000000 on consecutive cycles; also push 13'h0001 mode 11 -> 32'h00080000.
REQ-035 outReady=0; push A=13'h0005, B=13'h1FFE, C, all mode 00 -> level 1 then 2, inReady=0, C not accepted, numOut held at 32'h00000005; raise outReady -> 32'h00000005 then 32'hFFFFFFFE.
REQ-036 Stream 100 random pushes with random outReady -> outputs match the golden model in order, and level never exceeds 2.
REQ-037 With level=2, drive nRst=0 for one edge while pushing and popping -> level=0, outValid=0, numOut=0; the next push after release appears alone one cycle later.
